writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Write-back stage plus integer register file for the 5-stage RV32I pipeline. It consumes the outputs of the MEM/WB pipeline register and selects the write-back value: ALU result, or load data sign- or zero-extended by access size and byte offset. It commits that value to a 32×32 register file and serves the two decode-stage read ports. A write-first bypass makes the same-cycle write visible to decode, so no WB→ID forwarding path is needed elsewhere.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, number of architectural registers; index width is clog2(NREGS) = 5

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears every register-file entry
- RegWriteW  in  1  write enable from MEM/WB
- WriteBackW  in  1  0 = ALUResultW, 1 = extended load data
- LoadSizeW  in  3  funct3 of the load; ignored when WriteBackW = 0
- ALUResultW  in  32  ALU result; for loads, the effective address, whose bits [1:0] give the byte offset
- ReadDataW  in  32  raw aligned word from data memory
- RdW  in  5  destination register
- Rs1D, Rs2D  in  5  decode read addresses
- RD1D, RD2D  out  32  decode read data
- ResultW  out  32  selected write-back value, exported for the hazard/forwarding unit

## Operation
- Load extraction by byte offset off = ALUResultW[1:0]:
  - byte = ReadDataW[8·off+7 : 8·off]
  - half = ReadDataW[31:16] if ALUResultW[1] = 1, else ReadDataW[15:0]; ALUResultW[0] is ignored for halfwords
- LoadSizeW decode:
  - 000 LB → sign-extend byte
  - 001 LH → sign-extend half
  - 010 LW → full word
  - 100 LBU → zero-extend byte
  - 101 LHU → zero-extend half
  - 011, 110, 111 → treated as LW, no trap
- ResultW = WriteBackW ? extended load data : ALUResultW. Purely combinational from the W inputs.
- Commit: on a rising edge with reset = 0, RegWriteW = 1 and RdW ≠ 0, entry[RdW] ← ResultW.
- x0 is never written and always reads 0.
- Read port n (n = 1, 2), combinational:
  - Rs = 0 → 0
  - else RegWriteW = 1 and Rs = RdW → ResultW (bypass)
  - else entry[Rs]
- Both read ports may address the same register, or RdW, simultaneously; both return the identical value.
- Reset takes priority over a write in the same cycle: the write is dropped and the entry reads 0 after the edge.
- Reset mid-program: the next edge clears everything. No partial state survives.

## Timing
- Write latency: one edge. The value is stored at the edge ending the cycle in which RegWriteW = 1.
- Bypass latency: zero. During that same cycle, reads of RdW already return ResultW.
- After the edge, reads come from the array with an identical value, so there is no glitch across the boundary.
- Reset values:
  - all 31 stored entries = 0, so RD1D = RD2D = 0 for every address after reset
  - ResultW has no reset value; it follows its inputs combinationally
- No handshake. The block commits every cycle RegWriteW is asserted. Stall and flush are handled upstream by zeroing RegWriteW in MEM/WB.
- Single clock domain; all state updates on the rising edge of clk.

## Structure
- Shared package rv32_pkg holds:
  - LoadSizeW encodings: LB, LH, LW, LBU, LHU
  - XLEN
  - REG_IDX_W = 5
- One natural sub-module: load_extend (combinational). Inputs: ReadDataW, ALUResultW[1:0], LoadSizeW. Output: the extended 32-bit value. It is instantiated here and reusable for a future non-blocking load unit.
- The register array and bypass logic stay in the top module.

## Test plan
- Reset then read all: assert reset for 2 cycles, sweep Rs1D/Rs2D over 0..31 → every read returns 0x00000000.
- ALU write and bypass:
  - RegWriteW = 1, WriteBackW = 0, RdW = 5, ALUResultW = 0xDEADBEEF, Rs1D = 5 → RD1D = 0xDEADBEEF in the same cycle.
  - With RegWriteW = 0 the next cycle → RD1D still reads 0xDEADBEEF.
- x0 protection: write RdW = 0, ALUResultW = 0x12345678 → Rs1D = Rs2D = 0 return 0, both in the write cycle and after it.
- Load extension, ReadDataW = 0x80F07F01:
  - LB, off = 3 → 0xFFFFFF80
  - LBU, off = 3 → 0x00000080
  - LB, off = 1 → 0x0000007F
  - LH, off = 2 → 0xFFFF80F0
  - LHU, off = 0 → 0x00007F01
  - LW → 0x80F07F01
  - LoadSizeW = 111 → 0x80F07F01
- Reset vs write collision: reg 7 holds 0xAAAA5555. In one cycle assert RegWriteW = 1, RdW = 7, ALUResultW = 0x11111111 together with reset = 1 → reg 7 reads 0 after the edge.
- Dual-port same register: Rs1D = Rs2D = RdW = 9 with a write of 0xCAFEF00D → both RD1D and RD2D = 0xCAFEF00D; a random regression against a reference array model passes over 10k cycles.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath width, register index width and load funct3 encodings.
package rv32_pkg;

   localparam int XLEN      = 32;
   localparam int NREGS     = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_size_e;

endpackage

// File: rtl/writeback_regfile_load_extend.sv
// Load data extraction and sign/zero extension by size and byte offset.
// Purely combinational; no handshake.
module load_extend
   import rv32_pkg::*;
(
   input  logic [XLEN-1:0] ReadDataW,
   input  logic [1:0]      ByteOffsetW,
   input  logic [2:0]      LoadSizeW,
   output logic [XLEN-1:0] LoadExtW
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = ReadDataW[7:0];
      case (ByteOffsetW)
         2'd0: byte_sel = ReadDataW[7:0];
         2'd1: byte_sel = ReadDataW[15:8];
         2'd2: byte_sel = ReadDataW[23:16];
         2'd3: byte_sel = ReadDataW[31:24];
         default: byte_sel = ReadDataW[7:0];
      endcase
   end

   // Halfword offset bit 0 is ignored: misaligned halves are never split.
   assign half_sel = ByteOffsetW[1] ? ReadDataW[31:16] : ReadDataW[15:0];

   always_comb begin
      LoadExtW = ReadDataW;
      case (LoadSizeW)
         LB:      LoadExtW = {{24{byte_sel[7]}}, byte_sel};
         LH:      LoadExtW = {{16{half_sel[15]}}, half_sel};
         LBU:     LoadExtW = {24'h0, byte_sel};
         LHU:     LoadExtW = {16'h0, half_sel};
         default: LoadExtW = ReadDataW;
      endcase
   end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back select plus 32x32 register file with write-first bypass to both decode read ports.
// Commit on the rising edge when RegWriteW=1 and RdW!=0; reads and bypass are zero-latency; no backpressure.
module writeback_regfile
   import rv32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      RegWriteW,
   input  logic                      WriteBackW,
   input  logic [2:0]                LoadSizeW,
   input  logic [XLEN-1:0]           ALUResultW,
   input  logic [XLEN-1:0]           ReadDataW,
   input  logic [$clog2(NREGS)-1:0]  RdW,
   input  logic [$clog2(NREGS)-1:0]  Rs1D,
   input  logic [$clog2(NREGS)-1:0]  Rs2D,
   output logic [XLEN-1:0]           RD1D,
   output logic [XLEN-1:0]           RD2D,
   output logic [XLEN-1:0]           ResultW
);

   localparam int IDX_W = $clog2(NREGS);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [XLEN-1:0] load_ext;
   logic            commit;

   load_extend u_load_extend (
      .ReadDataW   (ReadDataW),
      .ByteOffsetW (ALUResultW[1:0]),
      .LoadSizeW   (LoadSizeW),
      .LoadExtW    (load_ext)
   );

   assign ResultW = WriteBackW ? load_ext : ALUResultW;
   assign commit  = RegWriteW && (RdW != '0);

   always_comb begin
      regs_d = regs_q;
      if (commit) begin
         regs_d[RdW] = ResultW;
      end
   end

   // Reset wins over a same-cycle write; entry 0 is cleared and never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [IDX_W-1:0] rs);
      if (rs == '0)                   return '0;
      else if (RegWriteW && rs == RdW) return ResultW;
      else                             return regs_q[rs];
   endfunction

   always_comb begin
      RD1D = read_port(Rs1D);
      RD2D = read_port(Rs2D);
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized and directed bench for writeback_regfile against an array reference model.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteW;
   logic        WriteBackW;
   logic [2:0]  LoadSizeW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [4:0]  RdW;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [31:0] ResultW;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] ref_rf [32];

   writeback_regfile dut (
      .clk        (clk),
      .reset      (reset),
      .RegWriteW  (RegWriteW),
      .WriteBackW (WriteBackW),
      .LoadSizeW  (LoadSizeW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .RdW        (RdW),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RD1D       (RD1D),
      .RD2D       (RD2D),
      .ResultW    (ResultW)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference write-back value from the load rules, using plain shift/mask arithmetic.
   function automatic logic [31:0] model_result(input logic wb, input logic [2:0] sz,
                                                input logic [31:0] addr, input logic [31:0] rd);
      int unsigned off = int'(addr[1:0]);
      int unsigned b   = (rd >> (8 * off)) & 32'hFF;
      int unsigned h   = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!wb) return addr;
      case (sz)
         3'd0:    return (b >= 128) ? 32'(int'(b) - 256)   : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] rs);
      if (rs == 5'd0) return 32'h0;
      if (RegWriteW && rs == RdW)
         return model_result(WriteBackW, LoadSizeW, ALUResultW, ReadDataW);
      return ref_rf[rs];
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      end else if (RegWriteW && RdW != 5'd0) begin
         ref_rf[RdW] = model_result(WriteBackW, LoadSizeW, ALUResultW, ReadDataW);
      end
      #1;
   endtask

   task automatic drive_write(input logic [4:0] rd, input logic [31:0] val);
      RegWriteW  = 1'b1;
      WriteBackW = 1'b0;
      RdW        = rd;
      ALUResultW = val;
   endtask

   task automatic load_case(input string tag, input logic [2:0] sz, input logic [1:0] off,
                            input logic [31:0] exp);
      WriteBackW = 1'b1;
      RegWriteW  = 1'b0;
      LoadSizeW  = sz;
      ReadDataW  = 32'h80F07F01;
      ALUResultW = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | {30'h0, off};
      #1;
      check_eq(tag, ResultW, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
      reset = 1'b1; RegWriteW = 1'b0; WriteBackW = 1'b0; LoadSizeW = 3'd2;
      ALUResultW = 32'h0; ReadDataW = 32'h0; RdW = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      tick(); tick();
      reset = 1'b0;

      for (int i = 0; i < 32; i++) begin
         Rs1D = 5'(i); Rs2D = 5'(31 - i);
         #1;
         check_eq("reset_rd1", RD1D, 32'h0);
         check_eq("reset_rd2", RD2D, 32'h0);
      end

      drive_write(5'd5, 32'hDEADBEEF); Rs1D = 5'd5; Rs2D = 5'd0;
      #1;
      check_eq("alu_bypass", RD1D, 32'hDEADBEEF);
      check_eq("alu_result", ResultW, 32'hDEADBEEF);
      tick();
      RegWriteW = 1'b0;
      #1;
      check_eq("alu_stored", RD1D, 32'hDEADBEEF);

      drive_write(5'd0, 32'h12345678); Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      check_eq("x0_wr_rd1", RD1D, 32'h0);
      check_eq("x0_wr_rd2", RD2D, 32'h0);
      tick();
      RegWriteW = 1'b0;
      #1;
      check_eq("x0_after_rd1", RD1D, 32'h0);
      check_eq("x0_after_rd2", RD2D, 32'h0);

      load_case("lb_off3",  3'b000, 2'd3, 32'hFFFFFF80);
      load_case("lbu_off3", 3'b100, 2'd3, 32'h00000080);
      load_case("lb_off1",  3'b000, 2'd1, 32'h0000007F);
      load_case("lh_off2",  3'b001, 2'd2, 32'hFFFF80F0);
      load_case("lh_off3",  3'b001, 2'd3, 32'hFFFF80F0);
      load_case("lhu_off0", 3'b101, 2'd0, 32'h00007F01);
      load_case("lw",       3'b010, 2'd0, 32'h80F07F01);
      load_case("ls_111",   3'b111, 2'd2, 32'h80F07F01);
      WriteBackW = 1'b0;

      drive_write(5'd7, 32'hAAAA5555); Rs1D = 5'd7;
      tick();
      RegWriteW = 1'b0;
      #1;
      check_eq("r7_pre", RD1D, 32'hAAAA5555);
      drive_write(5'd7, 32'h11111111); reset = 1'b1;
      tick();
      reset = 1'b0; RegWriteW = 1'b0;
      #1;
      check_eq("rst_vs_wr", RD1D, 32'h0);
      Rs1D = 5'd5;
      #1;
      check_eq("rst_clears_r5", RD1D, 32'h0);

      drive_write(5'd9, 32'hCAFEF00D); Rs1D = 5'd9; Rs2D = 5'd9;
      #1;
      check_eq("dual_byp_rd1", RD1D, 32'hCAFEF00D);
      check_eq("dual_byp_rd2", RD2D, 32'hCAFEF00D);
      tick();
      RegWriteW = 1'b0;
      #1;
      check_eq("dual_st_rd1", RD1D, 32'hCAFEF00D);
      check_eq("dual_st_rd2", RD2D, 32'hCAFEF00D);

      for (int c = 0; c < 10000; c++) begin
         reset      = ($urandom_range(0, 299) == 0);
         RegWriteW  = ($urandom_range(0, 3) != 0);
         WriteBackW = $urandom_range(0, 1) == 1;
         LoadSizeW  = 3'($urandom_range(0, 7));
         ALUResultW = $urandom;
         ReadDataW  = $urandom;
         RdW        = 5'($urandom_range(0, 31));
         Rs1D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
         Rs2D       = ($urandom_range(0, 3) == 0) ? Rs1D : 5'($urandom_range(0, 31));
         #2;
         check_eq("rnd_result", ResultW, model_result(WriteBackW, LoadSizeW, ALUResultW, ReadDataW));
         check_eq("rnd_rd1", RD1D, model_read(Rs1D));
         check_eq("rnd_rd2", RD2D, model_read(Rs2D));
         tick();
      end

      reset = 1'b0; RegWriteW = 1'b0;
      for (int i = 0; i < 32; i++) begin
         Rs1D = 5'(i); Rs2D = 5'(i);
         #1;
         check_eq("final_rd1", RD1D, model_read(Rs1D));
         check_eq("final_rd2", RD2D, model_read(Rs2D));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
